// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
// Scan codes are PS/2 set 2.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POP,
      ST_DEC,
      ST_EMIT
   } ps2_state_e;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   localparam logic [7:0] SC_NUL    = 8'h00;
   localparam logic [7:0] SC_ERR    = 8'hFF;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;

   function automatic logic is_discard(input logic [7:0] b);
      return (b == SC_NUL) || (b == SC_ERR) || (b == SC_PAUSE);
   endfunction

   function automatic logic is_modifier(input logic [7:0] b);
      return (b == SC_LSHIFT) || (b == SC_RSHIFT) || (b == SC_CAPS);
   endfunction

endpackage

// File: rtl/key_held_map.sv
// 512x1 bitmap of currently held keys, indexed by {ext, code}.
// Synchronous single-bit write, combinational read, async clear.
module key_held_map
   import ps2_pkg::*;
(
   input  logic       clk,
   input  logic       clrn,
   input  logic [8:0] rd_idx,
   output logic       rd_bit,
   input  logic       wr_en,
   input  logic [8:0] wr_idx,
   input  logic       wr_val
);

   logic [511:0] map_q;
   logic [511:0] map_d;

   always_comb begin
      map_d = map_q;
      if (wr_en) map_d[wr_idx] = wr_val;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) map_q <= '0;
      else       map_q <= map_d;
   end

   assign rd_bit = map_q[rd_idx];

endmodule

// File: rtl/ps2_key_sequencer.sv
// Drains the PS/2 scan-code FIFO and assembles bytes into key events.
// Define PS2SEQ_TYPEMATIC_EN to emit typematic repeats with ev_repeat=1.
module ps2_key_sequencer
   import ps2_pkg::*;
(
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       kb_nextdata_n,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       ev_repeat,
   output logic       shift,
   output logic       caps,
   output logic [7:0] key_count,
   output logic       ovf_seen
);

   ps2_state_e state_q, state_d;

   logic [7:0] byte_q, byte_d;
   logic       nd_q, nd_d;
   logic       ext_f_q, ext_f_d;
   logic       brk_f_q, brk_f_d;
   logic       ev_valid_q, ev_valid_d;
   logic [7:0] ev_code_q, ev_code_d;
   logic       ev_ext_q, ev_ext_d;
   logic       ev_break_q, ev_break_d;
   logic       lshift_q, lshift_d;
   logic       rshift_q, rshift_d;
   logic       shift_q, shift_d;
   logic       caps_q, caps_d;
   logic [7:0] key_count_q, key_count_d;
   logic       ovf_q, ovf_d;

   logic is_ext, is_brk, is_disc, is_key;
   logic is_mod, is_rpt, do_emit;
   logic hm_rd, hm_wr_en, hm_wr_val;

   key_held_map u_held (
      .clk    (clk),
      .clrn   (clrn),
      .rd_idx ({ext_f_q, byte_q}),
      .rd_bit (hm_rd),
      .wr_en  (hm_wr_en),
      .wr_idx ({ext_f_q, byte_q}),
      .wr_val (hm_wr_val)
   );

   always_comb begin
      is_ext  = (byte_q == SC_EXT);
      is_brk  = (byte_q == SC_BRK);
      is_disc = is_discard(byte_q);
      is_key  = !(is_ext || is_brk || is_disc);
      is_mod  = !ext_f_q && is_modifier(byte_q);
      is_rpt  = is_key && !brk_f_q && hm_rd;
`ifdef PS2SEQ_TYPEMATIC_EN
      do_emit = is_key;
`else
      do_emit = is_key && !is_rpt;
`endif
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (kb_ready) state_d = ST_POP;
         ST_POP:  state_d = ST_DEC;
         ST_DEC:  state_d = do_emit ? ST_EMIT : ST_IDLE;
         ST_EMIT: if (ev_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_d      = byte_q;
      nd_d        = 1'b1;
      ext_f_d     = ext_f_q;
      brk_f_d     = brk_f_q;
      ev_valid_d  = ev_valid_q;
      ev_code_d   = ev_code_q;
      ev_ext_d    = ev_ext_q;
      ev_break_d  = ev_break_q;
      lshift_d    = lshift_q;
      rshift_d    = rshift_q;
      caps_d      = caps_q;
      key_count_d = key_count_q;
      hm_wr_en    = 1'b0;
      hm_wr_val   = !brk_f_q;
      ovf_d       = ovf_q | kb_overflow;
      unique case (state_q)
         ST_IDLE: begin
            if (kb_ready) begin
               byte_d = kb_data;
               nd_d   = 1'b0;
            end
         end
         ST_DEC: begin
            if (is_ext) ext_f_d = 1'b1;
            if (is_brk) brk_f_d = 1'b1;
            if (is_disc || is_key) begin
               ext_f_d = 1'b0;
               brk_f_d = 1'b0;
            end
            if (do_emit) begin
               hm_wr_en   = 1'b1;
               ev_valid_d = 1'b1;
               ev_code_d  = byte_q;
               ev_ext_d   = ext_f_q;
               ev_break_d = brk_f_q;
               if (!ext_f_q && byte_q == SC_LSHIFT) lshift_d = !brk_f_q;
               if (!ext_f_q && byte_q == SC_RSHIFT) rshift_d = !brk_f_q;
               // Caps toggles on the first press only, never on repeats
               if (!ext_f_q && byte_q == SC_CAPS && !brk_f_q && !is_rpt)
                  caps_d = !caps_q;
               if (!brk_f_q && !is_mod)
                  key_count_d = key_count_q + 8'd1;
            end
         end
         ST_EMIT: if (ev_ready) ev_valid_d = 1'b0;
         default: ;
      endcase
      shift_d = lshift_d | rshift_d;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         byte_q      <= '0;
         nd_q        <= 1'b1;
         ext_f_q     <= 1'b0;
         brk_f_q     <= 1'b0;
         ev_valid_q  <= 1'b0;
         ev_code_q   <= '0;
         ev_ext_q    <= 1'b0;
         ev_break_q  <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         shift_q     <= 1'b0;
         caps_q      <= 1'b0;
         key_count_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         byte_q      <= byte_d;
         nd_q        <= nd_d;
         ext_f_q     <= ext_f_d;
         brk_f_q     <= brk_f_d;
         ev_valid_q  <= ev_valid_d;
         ev_code_q   <= ev_code_d;
         ev_ext_q    <= ev_ext_d;
         ev_break_q  <= ev_break_d;
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         shift_q     <= shift_d;
         caps_q      <= caps_d;
         key_count_q <= key_count_d;
         ovf_q       <= ovf_d;
      end
   end

`ifdef PS2SEQ_TYPEMATIC_EN
   logic rep_q, rep_d;

   always_comb begin
      rep_d = rep_q;
      if (state_q == ST_DEC && do_emit) rep_d = is_rpt;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) rep_q <= 1'b0;
      else       rep_q <= rep_d;
   end

   assign ev_repeat = rep_q;
`else
   assign ev_repeat = 1'b0;
`endif

   assign kb_nextdata_n = nd_q;
   assign ev_valid      = ev_valid_q;
   assign ev_code       = ev_code_q;
   assign ev_ext        = ev_ext_q;
   assign ev_break      = ev_break_q;
   assign shift         = shift_q;
   assign caps          = caps_q;
   assign key_count     = key_count_q;
   assign ovf_seen      = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: keyboard FIFO model, event-level
// reference model and per-cycle output checker.
module tb_ps2_key_sequencer;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_overflow = 1'b0;
   logic       kb_nextdata_n;
   logic       ev_valid;
   logic       ev_ready = 1'b1;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_repeat;
   logic       shift;
   logic       caps;
   logic [7:0] key_count;
   logic       ovf_seen;

   ps2_key_sequencer dut (
      .clk           (clk),
      .clrn          (clrn),
      .kb_data       (kb_data),
      .kb_ready      (kb_ready),
      .kb_overflow   (kb_overflow),
      .kb_nextdata_n (kb_nextdata_n),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_code       (ev_code),
      .ev_ext        (ev_ext),
      .ev_break      (ev_break),
      .ev_repeat     (ev_repeat),
      .shift         (shift),
      .caps          (caps),
      .key_count     (key_count),
      .ovf_seen      (ovf_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic       sh;
      logic       cp;
      logic [7:0] cnt;
   } ev_t;

   int nvec = 0;
   int nerr = 0;
   int pops = 0;
   logic prev_nd_low = 1'b0;

   logic [7:0] kbq[$];
   ev_t        exp_q[$];

   // model state
   logic       m_ext, m_brk, m_ls, m_rs, m_caps;
   logic [7:0] m_cnt;
   logic       m_held [512];
   // state after the last accepted event
   logic       cur_sh, cur_cp;
   logic [7:0] cur_cnt;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input ev_t e);
      return {8'h00, e.code, e.cnt, 3'b000, e.ext, e.brk, e.rep, e.sh, e.cp};
   endfunction

   function automatic void model_reset();
      m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_cnt = 0;
      for (int i = 0; i < 512; i++) m_held[i] = 1'b0;
      cur_sh = 0; cur_cp = 0; cur_cnt = 0;
      exp_q.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int   idx;
      logic mod, rep, emit;
      ev_t  e;
      if (b == 8'hE0) begin m_ext = 1; return; end
      if (b == 8'hF0) begin m_brk = 1; return; end
      if (b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
         m_ext = 0; m_brk = 0; return;
      end
      idx  = m_ext ? 256 + int'(b) : int'(b);
      mod  = !m_ext && (b == 8'h12 || b == 8'h59 || b == 8'h58);
      rep  = !m_brk && m_held[idx];
`ifdef PS2SEQ_TYPEMATIC_EN
      emit = 1'b1;
`else
      emit = !rep;
`endif
      if (emit) begin
         m_held[idx] = !m_brk;
         if (!m_ext && b == 8'h12) m_ls = !m_brk;
         if (!m_ext && b == 8'h59) m_rs = !m_brk;
         if (!m_ext && b == 8'h58 && !m_brk && !rep) m_caps = !m_caps;
         if (!m_brk && !mod) m_cnt = m_cnt + 8'd1;
         e.code = b; e.ext = m_ext; e.brk = m_brk;
         e.rep = m_brk ? 1'b0 : rep;
         e.sh = m_ls | m_rs; e.cp = m_caps; e.cnt = m_cnt;
         exp_q.push_back(e);
      end
      m_ext = 0; m_brk = 0;
   endfunction

   task automatic push(input logic [7:0] b);
      kbq.push_back(b);
      model_byte(b);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk); #1;
      ev_ready = v;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && kbq.size() == 0) break;
      end
      repeat (6) @(negedge clk);
      chk({name, " drain"}, exp_q.size(), 0);
   endtask

   // keyboard FIFO: pop on each registered pop strobe
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!clrn) kbq.delete();
         else if (!kb_nextdata_n && kbq.size() > 0) void'(kbq.pop_front());
         kb_ready = (kbq.size() > 0);
         kb_data  = (kbq.size() > 0) ? kbq[0] : 8'h00;
      end
   end

   // compare process
   always @(negedge clk) begin
      if (clrn) begin
         if (!kb_nextdata_n) begin
            pops++;
            chk("pop not back-to-back", {31'd0, prev_nd_low}, 0);
            chk("pop while event pending", {31'd0, ev_valid}, 0);
         end
         prev_nd_low = !kb_nextdata_n;
         if (ev_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected event", {24'd0, ev_code}, 32'hFFFF_FFFF);
            end else begin
               ev_t a;
               a.code = ev_code; a.ext = ev_ext; a.brk = ev_break;
               a.rep = ev_repeat; a.sh = shift; a.cp = caps;
               a.cnt = key_count;
               chk("event", pack(a), pack(exp_q[0]));
               if (ev_ready) begin
                  cur_sh = exp_q[0].sh; cur_cp = exp_q[0].cp;
                  cur_cnt = exp_q[0].cnt;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("idle status", {22'd0, shift, caps, key_count},
                {22'd0, cur_sh, cur_cp, cur_cnt});
         end
      end else begin
         prev_nd_low = 1'b0;
      end
   end

   initial begin
      int p0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst nextdata_n", {31'd0, kb_nextdata_n}, 1);
      chk("rst ev_valid", {31'd0, ev_valid}, 0);
      chk("rst ev_code", {24'd0, ev_code}, 0);
      chk("rst flags", {28'd0, ev_ext, ev_break, ev_repeat, ovf_seen}, 0);
      chk("rst shift/caps", {30'd0, shift, caps}, 0);
      chk("rst key_count", {24'd0, key_count}, 0);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // make/break of A-key region code 1C
      pops = 0;
      push(8'h1C); push(8'hF0); push(8'h1C);
      chk("model t1 n", exp_q.size(), 2);
      chk("model t1 e0", pack(exp_q[0]), 32'h001C_0100);
      chk("model t1 e1", pack(exp_q[1]), 32'h001C_0108);
      drain("t1");
      chk("t1 key_count", {24'd0, key_count}, 1);
      chk("t1 pops", pops, 3);

      // extended make/break
      push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
      chk("model t2 e0", pack(exp_q[0]), 32'h0075_0210);
      chk("model t2 e1", pack(exp_q[1]), 32'h0075_0218);
      drain("t2");
      chk("t2 key_count", {24'd0, key_count}, 2);

      // shift held across a key
      push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
      push(8'hF0); push(8'h1C);
      chk("model t3 e1", pack(exp_q[1]), 32'h001C_0302);
      chk("model t3 e2", pack(exp_q[2]), 32'h0012_0308);
      drain("t3");
      chk("t3 shift", {31'd0, shift}, 0);
      chk("t3 key_count", {24'd0, key_count}, 3);

      // caps lock toggling
      push(8'h58); push(8'hF0); push(8'h58); push(8'h58);
      chk("model t4 e0", pack(exp_q[0]), 32'h0058_0301);
      chk("model t4 e2", pack(exp_q[2]), 32'h0058_0300);
      drain("t4a");
      chk("t4 caps", {31'd0, caps}, 0);
      chk("t4 key_count", {24'd0, key_count}, 3);
      push(8'hF0); push(8'h58);
      drain("t4b");

      // held key pressed repeatedly
      push(8'h1C); push(8'h1C); push(8'h1C);
`ifdef PS2SEQ_TYPEMATIC_EN
      chk("model t5 n", exp_q.size(), 3);
      chk("model t5 e2", pack(exp_q[2]), 32'h001C_0604);
      drain("t5");
      chk("t5 key_count", {24'd0, key_count}, 6);
`else
      chk("model t5 n", exp_q.size(), 1);
      drain("t5");
      chk("t5 key_count", {24'd0, key_count}, 4);
`endif
      push(8'hF0); push(8'h1C);
      drain("t5b");

      // downstream stall back-pressures the keyboard FIFO
      set_ready(1'b0);
      push(8'h1C); push(8'h32); push(8'h21); push(8'h23); push(8'h24);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ev_valid) break;
      end
      p0 = pops;
      repeat (30) @(negedge clk);
      chk("stall valid", {31'd0, ev_valid}, 1);
      chk("stall code", {24'd0, ev_code}, 32'h1C);
      chk("stall no pops", pops - p0, 0);
      chk("stall backlog", kbq.size(), 4);
      set_ready(1'b1);
      drain("t6");
`ifdef PS2SEQ_TYPEMATIC_EN
      chk("t6 key_count", {24'd0, key_count}, 11);
`else
      chk("t6 key_count", {24'd0, key_count}, 9);
`endif

      // overflow is sticky
      chk("ovf before", {31'd0, ovf_seen}, 0);
      @(posedge clk); #1 kb_overflow = 1'b1;
      @(posedge clk); #1 kb_overflow = 1'b0;
      repeat (3) @(negedge clk);
      chk("ovf sticky", {31'd0, ovf_seen}, 1);

      // reset mid-stream
      set_ready(1'b0);
      push(8'h2B); push(8'h34);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ev_valid) break;
      end
      chk("t8 pending", {31'd0, ev_valid}, 1);
      @(posedge clk); #1 clrn = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("mid rst nextdata_n", {31'd0, kb_nextdata_n}, 1);
      chk("mid rst outs", {17'd0, ev_valid, ev_ext, ev_break, ev_repeat,
          shift, caps, ovf_seen, ev_code}, 0);
      chk("mid rst key_count", {24'd0, key_count}, 0);
      @(posedge clk); #1 clrn = 1'b1;
      ev_ready = 1'b1;
      repeat (2) @(negedge clk);
      push(8'h2B);
      drain("t8");
      chk("t8 key_count", {24'd0, key_count}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
